// File: rtl/sp_bram_stream_reader_if.sv
// Bus bundle for sp_bram_stream_reader: single-port BRAM read port plus the
// outgoing valid/ready stream. master = reader side, slave = BRAM + consumer side.
interface sp_bram_stream_reader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] addr0;
    logic              ce0;
    logic              we0;
    logic [DATA_W-1:0] o_data0;

    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport master (
        output addr0, ce0, we0, m_valid, m_data, m_last,
        input  o_data0, m_ready
    );

    modport slave (
        input  addr0, ce0, we0, m_valid, m_data, m_last,
        output o_data0, m_ready
    );
endinterface

// File: rtl/sp_bram_stream_reader.sv
// Reads a contiguous BRAM window on a start pulse and streams it out with valid/ready/last.
// Define BRAM_OUTREG_EN when the BRAM has an output register (read latency 2 instead of 1).
module sp_bram_stream_reader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 11,
    parameter int BUF_D  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic [LEN_W-1:0]       len,
    output logic                   busy,
    output logic                   done,
    sp_bram_stream_reader_if.master bus
);

`ifdef BRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam int PTR_W = (BUF_D > 1) ? $clog2(BUF_D) : 1;
    localparam int CNT_W = $clog2(BUF_D) + 1;
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issue_left_q;
    logic [LEN_W-1:0]  beat_q;
    logic              done_q, done_d;

    logic [LAT-1:0]    ret_vld_p;
    logic [DATA_W-1:0] buf_mem [BUF_D];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  buf_count_q;

    logic              issue, load, push, pop, buf_empty, head_last;
    logic [CNT_W-1:0]  inflight, occupancy;

    function automatic logic [CNT_W-1:0] count_inflight(input logic [LAT-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < LAT; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    // Every issued read reserves a buffer slot until it has been popped, so
    // returns can always be written even while the consumer stalls.
    assign inflight  = count_inflight(ret_vld_p);
    assign occupancy = buf_count_q + inflight;
    assign buf_empty = (buf_count_q == '0);
    assign push      = ret_vld_p[LAT-1];
    assign pop       = !buf_empty && bus.m_ready;
    assign head_last = (beat_q == (len_q - LEN_ONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        load    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        load    = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (occupancy < CNT_W'(BUF_D)) begin
                    issue = 1'b1;
                    if (issue_left_q == LEN_ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Popping the final beat implies nothing is buffered or in flight.
                if (pop && head_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage p0: read issue, return tracking and buffer bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= '0;
            len_q        <= '0;
            issue_left_q <= '0;
            beat_q       <= '0;
            done_q       <= 1'b0;
            ret_vld_p    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            buf_count_q  <= '0;
        end else begin
            done_q    <= done_d;
            ret_vld_p <= LAT'({ret_vld_p, issue});

            if (load) begin
                addr_q       <= base_addr;
                len_q        <= len;
                issue_left_q <= len;
                beat_q       <= '0;
            end else begin
                if (issue) begin
                    addr_q       <= addr_q + ADDR_W'(1);
                    issue_left_q <= issue_left_q - LEN_ONE;
                end
                if (pop) begin
                    beat_q <= beat_q + LEN_ONE;
                end
            end

            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   buf_count_q <= buf_count_q + CNT_W'(1);
                2'b01:   buf_count_q <= buf_count_q - CNT_W'(1);
                default: buf_count_q <= buf_count_q;
            endcase
        end
    end

    // Stage p1: return buffer storage
    always_ff @(posedge clk) begin
        if (push) begin
            buf_mem[wr_ptr_q] <= bus.o_data0;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign bus.addr0   = addr_q;
    assign bus.ce0     = issue;
    assign bus.we0     = 1'b0;
    assign bus.m_valid = !buf_empty;
    assign bus.m_data  = buf_empty ? '0 : buf_mem[rd_ptr_q];
    assign bus.m_last  = !buf_empty && head_last;

endmodule
